// File: rtl/imem_dmem_arb_pkg.sv
// Shared types and defaults for the I-cache / D-cache block-memory arbiter.
package imem_dmem_arb_pkg;

   localparam int unsigned DEF_ADDR_W         = 32;
   localparam int unsigned DEF_BLOCK_W        = 128;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

   typedef enum logic {
      GRANT_IC = 1'b0,
      GRANT_DC = 1'b1
   } grant_t;

endpackage

// File: rtl/imem_dmem_arbiter_rr_arbiter2.sv
// Two-input round-robin grant: combinational winner, remembered on accept.
module rr_arbiter2
   import imem_dmem_arb_pkg::*;
(
   input  logic   clock,
   input  logic   reset,
   input  logic   req_ic,
   input  logic   req_dc,
   input  logic   accept,
   output logic   grant_valid,
   output grant_t grant
);

   grant_t last_grant;

   // Pick the single requester, or on a tie the one that did not win last time.
   always_comb begin
      grant_valid = req_ic | req_dc;
      grant       = GRANT_IC;
      if (req_ic && req_dc) begin
         grant = (last_grant == GRANT_IC) ? GRANT_DC : GRANT_IC;
      end else if (req_dc) begin
         grant = GRANT_DC;
      end
   end

   // Remember the winner once the grant is actually taken; IC after reset so DC wins the first tie.
   always_ff @(posedge clock) begin
      if (reset) begin
         last_grant <= GRANT_IC;
      end else if (accept && grant_valid) begin
         last_grant <= grant;
      end
   end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one slow block-memory port between I-cache refill and D-cache refill/writeback.
module imem_dmem_arbiter
   import imem_dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W         = DEF_ADDR_W,
   parameter int unsigned BLOCK_W        = DEF_BLOCK_W,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               ic_req,
   input  logic [ADDR_W-1:0]  ic_addr,
   output logic               ic_ready,
   output logic [BLOCK_W-1:0] ic_rdata,
   input  logic               dc_req,
   input  logic               dc_we,
   input  logic [ADDR_W-1:0]  dc_addr,
   input  logic [BLOCK_W-1:0] dc_wdata,
   output logic               dc_ready,
   output logic [BLOCK_W-1:0] dc_rdata,
   output logic               mem_enable,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_address,
   output logic [BLOCK_W-1:0] mem_wdata,
   input  logic [BLOCK_W-1:0] mem_rdata,
   input  logic               mem_valid,
   output logic               timeout_err
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   arb_state_t       state;
   grant_t           grantee;
   logic [CNT_W-1:0] wd_cnt;

   logic   arb_valid;
   logic   arb_accept;
   grant_t arb_grant;

   // Grants are only taken while idle; requests arriving mid-access simply wait.
   always_comb begin
      arb_accept = (state == IDLE);
   end

   rr_arbiter2 u_rr (
      .clock       (clock),
      .reset       (reset),
      .req_ic      (ic_req),
      .req_dc      (dc_req),
      .accept      (arb_accept),
      .grant_valid (arb_valid),
      .grant       (arb_grant)
   );

   // Access sequencer: every output is a register updated alongside the state.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         grantee     <= GRANT_IC;
         wd_cnt      <= '0;
         ic_ready    <= 1'b0;
         ic_rdata    <= '0;
         dc_ready    <= 1'b0;
         dc_rdata    <= '0;
         mem_enable  <= 1'b0;
         mem_we      <= 1'b0;
         mem_address <= '0;
         mem_wdata   <= '0;
         timeout_err <= 1'b0;
      end else begin
         ic_ready <= 1'b0;
         dc_ready <= 1'b0;
         case (state)
            IDLE: begin
               mem_enable <= 1'b0;
               if (arb_valid) begin
                  grantee <= arb_grant;
                  if (arb_grant == GRANT_DC) begin
                     mem_address <= dc_addr;
                     mem_we      <= dc_we;
                     mem_wdata   <= dc_wdata;
                  end else begin
                     mem_address <= ic_addr;
                     mem_we      <= 1'b0;
                     mem_wdata   <= '0;
                  end
                  // Enable rises together with ISSUE so memory sees the edge in that cycle.
                  mem_enable <= 1'b1;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               wd_cnt <= '0;
               state  <= WAIT;
            end
            WAIT: begin
               if (mem_valid) begin
                  if (grantee == GRANT_IC) begin
                     ic_rdata <= mem_rdata;
                     ic_ready <= 1'b1;
                  end else begin
                     if (!mem_we) begin
                        dc_rdata <= mem_rdata;
                     end
                     dc_ready <= 1'b1;
                  end
                  mem_enable <= 1'b0;
                  state      <= RESP;
               end else if (wd_cnt == CNT_LIMIT) begin
                  if (grantee == GRANT_IC) begin
                     ic_rdata <= '0;
                     ic_ready <= 1'b1;
                  end else begin
                     dc_rdata <= '0;
                     dc_ready <= 1'b1;
                  end
                  timeout_err <= 1'b1;
                  mem_enable  <= 1'b0;
                  state       <= RESP;
               end else begin
                  wd_cnt <= wd_cnt + CNT_ONE;
               end
            end
            RESP: begin
               mem_enable <= 1'b0;
               state      <= IDLE;
            end
            default: begin
               mem_enable <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Scoreboard bench: a transaction-timeline reference model predicts grant order,
// ready cycle and data; a monitor pops and compares on every ready pulse.
module tb_imem_dmem_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned BW = 128;
   localparam int unsigned T  = 32;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          ic_req = 1'b0;
   logic [AW-1:0] ic_addr = '0;
   logic          ic_ready;
   logic [BW-1:0] ic_rdata;
   logic          dc_req = 1'b0;
   logic          dc_we = 1'b0;
   logic [AW-1:0] dc_addr = '0;
   logic [BW-1:0] dc_wdata = '0;
   logic          dc_ready;
   logic [BW-1:0] dc_rdata;
   logic          mem_enable;
   logic          mem_we;
   logic [AW-1:0] mem_address;
   logic [BW-1:0] mem_wdata;
   logic [BW-1:0] mem_rdata = '0;
   logic          mem_valid = 1'b0;
   logic          timeout_err;

   imem_dmem_arbiter #(.ADDR_W(AW), .BLOCK_W(BW), .TIMEOUT_CYCLES(T)) dut (
      .clock(clock), .reset(reset),
      .ic_req(ic_req), .ic_addr(ic_addr), .ic_ready(ic_ready), .ic_rdata(ic_rdata),
      .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
      .dc_ready(dc_ready), .dc_rdata(dc_rdata),
      .mem_enable(mem_enable), .mem_we(mem_we), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
      .timeout_err(timeout_err)
   );

   always #5 clock = ~clock;

   int unsigned total = 0;
   int unsigned bad   = 0;
   int unsigned cyc   = 0;

   typedef struct {
      bit            port;   // 0 = IC, 1 = DC
      logic [31:0]   addr;
      bit            we;
      logic [127:0]  wdata;
      bit            hold;   // completed write: dc_rdata must keep its old value
      logic [127:0]  data;
      int unsigned   rcyc;
      bit            err;
   } exp_t;

   exp_t expq[$];
   logic [127:0] ref_mem [logic [31:0]];
   logic [127:0] env_mem [logic [31:0]];

   function automatic logic [127:0] blk_init(input logic [31:0] a);
      logic [31:0] k;
      k = a >> 4;
      return {k * 32'd3 + 32'd1, ~k, k ^ 32'h5A5A_5A5A, k + 32'h0000_1234};
   endfunction

   // Memory behaviour chosen by address: bit31 = never answers, bit10 = answers on the last legal cycle.
   function automatic bit drop_of(input logic [31:0] a);
      return a[31];
   endfunction

   function automatic int unsigned lat_of(input logic [31:0] a);
      if (a[10]) return T + 1;
      if (a[9])  return 1 + int'(a[5:4]);
      return 10 + int'(a[5:4]);
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: abstract timeline of a serial port with round-robin tie-break.
   int unsigned free_at = 0;
   bit          last_g  = 1'b0;
   bit          err_model = 1'b0;
   exp_t        m_e;
   bit          m_g;
   logic [31:0] m_key;

   always @(posedge clock) begin
      if (reset) begin
         expq.delete();
         free_at   = cyc + 1;
         last_g    = 1'b0;
         err_model = 1'b0;
      end else if (cyc >= free_at && (ic_req || dc_req)) begin
         if (ic_req && dc_req) m_g = !last_g;
         else                  m_g = dc_req;
         last_g    = m_g;
         m_e.port  = m_g;
         m_e.addr  = m_g ? dc_addr : ic_addr;
         m_e.we    = m_g ? dc_we : 1'b0;
         m_e.wdata = m_g ? dc_wdata : '0;
         m_key     = m_e.addr >> 4;
         m_e.hold  = 1'b0;
         m_e.data  = '0;
         if (m_e.we) ref_mem[m_key] = m_e.wdata;
         if (drop_of(m_e.addr)) begin
            err_model = 1'b1;
            m_e.rcyc  = cyc + T + 3;
         end else begin
            m_e.rcyc = cyc + lat_of(m_e.addr) + 2;
            if (m_e.we) m_e.hold = 1'b1;
            else m_e.data = ref_mem.exists(m_key) ? ref_mem[m_key] : blk_init(m_e.addr);
         end
         m_e.err = err_model;
         free_at = m_e.rcyc + 1;
         expq.push_back(m_e);
      end
      cyc++;
   end

   // Monitor: every ready pulse must match the oldest predicted completion.
   logic [127:0] last_ic = '0;
   logic [127:0] last_dc = '0;
   exp_t         mon_e;

   always @(negedge clock) begin
      if (reset) begin
         last_ic = '0;
         last_dc = '0;
      end else if (ic_ready || dc_ready) begin
         if (ic_ready && dc_ready) check("single_ready", 1'b1, 1'b0);
         if (expq.size() == 0) begin
            check("unexpected_ready", {ic_ready, dc_ready}, 2'b00);
         end else begin
            mon_e = expq.pop_front();
            check("grant_port", dc_ready, mon_e.port);
            check("ready_cycle", cyc, mon_e.rcyc);
            check("timeout_err", timeout_err, mon_e.err);
            if (mon_e.port) begin
               if (mon_e.hold) check("dc_rdata_hold", dc_rdata, last_dc);
               else begin
                  check("dc_rdata", dc_rdata, mon_e.data);
                  last_dc = mon_e.data;
               end
               check("ic_rdata_hold", ic_rdata, last_ic);
            end else begin
               check("ic_rdata", ic_rdata, mon_e.data);
               last_ic = mon_e.data;
               check("dc_rdata_hold", dc_rdata, last_dc);
            end
         end
      end
   end

   // Enable gap: at least two low cycles before every rising edge after the first.
   bit          g_prev = 1'b0;
   bit          g_seen = 1'b0;
   int unsigned g_low  = 0;

   always @(negedge clock) begin
      if (reset) begin
         g_prev = 1'b0;
         g_seen = 1'b0;
         g_low  = 0;
      end else begin
         if (mem_enable && !g_prev) begin
            if (g_seen) check("enable_gap_ge2", g_low >= 2, 1'b1);
            g_seen = 1'b1;
            g_low  = 0;
         end else if (!mem_enable) begin
            g_low++;
         end
         g_prev = mem_enable;
      end
   end

   // Memory environment: starts on a rising enable, answers after the address-selected latency.
   initial begin : mem_env
      bit          pend;
      bit          prev_en;
      int unsigned remain;
      logic [127:0] pdata;
      logic [31:0]  key;
      pend = 1'b0;
      prev_en = 1'b0;
      remain = 0;
      pdata = '0;
      forever begin
         @(negedge clock);
         if (reset) begin
            pend      = 1'b0;
            prev_en   = 1'b0;
            mem_valid = 1'b0;
         end else begin
            mem_valid = 1'b0;
            if (pend) begin
               remain--;
               if (remain == 0) begin
                  mem_valid = 1'b1;
                  mem_rdata = pdata;
                  pend      = 1'b0;
               end
            end
            if (mem_enable && !prev_en) begin
               key = mem_address >> 4;
               if (expq.size() == 0) begin
                  check("unexpected_access", 1'b1, 1'b0);
               end else begin
                  check("mem_address", mem_address, expq[0].addr);
                  check("mem_we", mem_we, expq[0].we);
                  if (expq[0].we) check("mem_wdata", mem_wdata, expq[0].wdata);
               end
               if (mem_we) env_mem[key] = mem_wdata;
               if (drop_of(mem_address)) begin
                  pdata  = {4{32'hBAD0_BAD0}};
                  remain = T + 3;
               end else begin
                  pdata  = env_mem.exists(key) ? env_mem[key] : blk_init(mem_address);
                  remain = lat_of(mem_address);
               end
               pend = 1'b1;
            end
            prev_en = mem_enable;
         end
      end
   end

   task automatic ic_request(input logic [31:0] a);
      bit done;
      done = 1'b0;
      @(negedge clock);
      ic_addr = a;
      ic_req  = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (ic_ready) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) check("ic_ready_timeout", 1'b0, 1'b1);
      ic_req = 1'b0;
   endtask

   task automatic dc_request(input bit we, input logic [31:0] a, input logic [127:0] wd);
      bit done;
      done = 1'b0;
      @(negedge clock);
      dc_we    = we;
      dc_addr  = a;
      dc_wdata = wd;
      dc_req   = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (dc_ready) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) check("dc_ready_timeout", 1'b0, 1'b1);
      dc_req = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ic_ready"}, ic_ready, 1'b0);
      check({tag, "_dc_ready"}, dc_ready, 1'b0);
      check({tag, "_ic_rdata"}, ic_rdata, '0);
      check({tag, "_dc_rdata"}, dc_rdata, '0);
      check({tag, "_mem_enable"}, mem_enable, 1'b0);
      check({tag, "_mem_we"}, mem_we, 1'b0);
      check({tag, "_mem_address"}, mem_address, '0);
      check({tag, "_mem_wdata"}, mem_wdata, '0);
      check({tag, "_timeout_err"}, timeout_err, 1'b0);
   endtask

   task automatic idle_cycles(input int unsigned n);
      repeat (n) @(negedge clock);
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = $urandom & 32'h0000_03F0;
      if ($urandom_range(0, 15) == 0) a[31] = 1'b1;
      if ($urandom_range(0, 15) == 0) a[10] = 1'b1;
      return a;
   endfunction

   initial begin : global_guard
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      repeat (3) @(negedge clock);
      check_reset_outputs("reset");
      reset = 1'b0;
      idle_cycles(2);

      // single IC read, latency 10
      ic_request(32'h0000_0040);
      idle_cycles(3);

      // simultaneous after reset: DC first, then IC
      fork
         ic_request(32'h0000_0080);
         dc_request(1'b0, 32'h0000_00C0, '0);
      join
      idle_cycles(3);

      // sustained contention: alternation over six accesses
      fork
         for (int i = 0; i < 3; i++) ic_request(32'h0000_0200 + 32'(i) * 32'h10);
         for (int j = 0; j < 3; j++) dc_request(1'b0, 32'h0000_0110 + 32'(j) * 32'h20, '0);
      join
      idle_cycles(3);

      // DC write then read back
      dc_request(1'b1, 32'h0000_0100,
                 {32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'hCAFE_F00D});
      idle_cycles(2);
      dc_request(1'b0, 32'h0000_0100, '0);
      idle_cycles(2);

      // timeout boundary: answer on the last legal cycle is still accepted
      ic_request(32'h0000_0440);
      idle_cycles(2);

      // timeout: memory never answers; late stray valid must not pulse ready
      ic_request(32'h8000_0040);
      idle_cycles(10);
      check("timeout_err_sticky", timeout_err, 1'b1);
      dc_request(1'b1, 32'h8000_0300, {4{32'h5555_AAAA}});
      idle_cycles(10);

      // reset while in WAIT
      @(negedge clock);
      ic_addr = 32'h0000_0080;
      ic_req  = 1'b1;
      idle_cycles(5);
      reset  = 1'b1;
      ic_req = 1'b0;
      @(negedge clock);
      check_reset_outputs("mid_reset");
      reset = 1'b0;
      idle_cycles(20);
      ic_request(32'h0000_0080);
      idle_cycles(2);

      // randomized traffic from both requesters
      fork
         for (int i = 0; i < 20; i++) begin
            idle_cycles($urandom_range(0, 4));
            ic_request(rand_addr());
         end
         for (int j = 0; j < 20; j++) begin
            idle_cycles($urandom_range(0, 4));
            dc_request(1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom, $urandom, $urandom});
         end
      join

      for (int k = 0; k < 200 && expq.size() != 0; k++) @(negedge clock);
      check("queue_drained", expq.size(), 0);
      idle_cycles(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
